// File: rtl/uart_tx_frame.sv
// uart_tx_frame: sends a burst of byte_len asynchronous serial characters taken from a wide packed bus.
// Define UART_TX_PARITY_EN to insert one parity bit (sense chosen by parity_odd) after each character.
module uart_tx_frame #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned MAX_BYTES    = 14,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [DATA_BITS*MAX_BYTES-1:0]     data_transmit,
    input  logic [$clog2(MAX_BYTES+1)-1:0]     byte_len,
    input  logic                               output_ena,
    input  logic                               parity_odd,
    output logic                               busy,
    output logic                               sent,
    output logic                               bit_out
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam int unsigned LEN_W = $clog2(MAX_BYTES + 1);
    localparam int unsigned PAY_W = DATA_BITS * MAX_BYTES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
`ifdef UART_TX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [LEN_W-1:0]   chr_q, chr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [PAY_W-1:0]   data_q, data_d;
    logic               busy_q, busy_d;
    logic               sent_q, sent_d;
    logic               line_q, line_d;
    logic               ena_q;

    logic                 trigger;
    logic                 bit_end;
    logic [CNT_W-1:0]     cnt_inc;
    logic [BIT_W-1:0]     bit_inc;
    logic [DATA_BITS-1:0] cur_char;
    logic [LEN_W-1:0]     len_clamped;

`ifdef UART_TX_PARITY_EN
    logic par_q, par_d;
    logic parity_bit;
    assign parity_bit = (^cur_char) ^ par_q;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    assign trigger     = output_ena & ~ena_q & ~busy_q;
    assign bit_end     = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign cnt_inc     = bit_end ? '0 : cnt_q + CNT_W'(1);
    assign bit_inc     = bit_q + BIT_W'(1);
    assign cur_char    = data_q[DATA_BITS-1:0];
    assign len_clamped = (byte_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : byte_len;

    // All state, counters and outputs are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            chr_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            sent_q  <= 1'b0;
            line_q  <= 1'b1;
            ena_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            chr_q   <= chr_d;
            len_q   <= len_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            sent_q  <= sent_d;
            line_q  <= line_d;
            ena_q   <= output_ena;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state and next-output logic; the line value is decided one edge ahead of each bit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        chr_d   = chr_q;
        len_d   = len_q;
        data_d  = data_q;
        busy_d  = busy_q;
        sent_d  = 1'b0;
        line_d  = line_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                line_d = 1'b1;
                if (trigger) begin
                    state_d = S_LOAD;
                    busy_d  = 1'b1;
                    data_d  = data_transmit;
                    len_d   = len_clamped;
`ifdef UART_TX_PARITY_EN
                    par_d   = parity_odd;
`endif
                end
            end
            S_LOAD: begin
                cnt_d = '0;
                bit_d = '0;
                chr_d = '0;
                if (len_q == '0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    sent_d  = 1'b1;
                end else begin
                    state_d = S_START;
                    line_d  = 1'b0;
                end
            end
            S_START: begin
                cnt_d = cnt_inc;
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    line_d  = cur_char[0];
                end
            end
            S_DATA: begin
                cnt_d = cnt_inc;
                if (bit_end) begin
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        line_d  = parity_bit;
`else
                        state_d = S_STOP;
                        line_d  = 1'b1;
`endif
                    end else begin
                        bit_d  = bit_inc;
                        line_d = cur_char[bit_inc];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                cnt_d = cnt_inc;
                if (bit_end) begin
                    state_d = S_STOP;
                    line_d  = 1'b1;
                end
            end
`endif
            S_STOP: begin
                cnt_d = cnt_inc;
                if (bit_end) begin
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        bit_d = '0;
                        if (chr_q == len_q - LEN_W'(1)) begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            sent_d  = 1'b1;
                        end else begin
                            // Next character follows with no idle gap
                            state_d = S_START;
                            chr_d   = chr_q + LEN_W'(1);
                            data_d  = data_q >> DATA_BITS;
                            line_d  = 1'b0;
                        end
                    end else begin
                        bit_d = bit_inc;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                line_d  = 1'b1;
            end
        endcase
    end

    assign busy    = busy_q;
    assign sent    = sent_q;
    assign bit_out = line_q;

endmodule
